// File: rtl/lcd_spectrum_display.sv
// Spectrum-bar pixel generator with ping-pong bin buffer
// and per-bar peak-hold markers for the RGB LCD path.
module lcd_spectrum_display #(
  parameter int H_DISP     = 480,
  parameter int V_DISP     = 800,
  parameter int N_BARS     = 128,
  parameter int IDX_W      = 7,
  parameter int MAG_W      = 16,
  parameter int BAR_PITCH  = 4,
  parameter int BAR_THICK  = 1,
  parameter int Y_OFFSET   = 8,
  parameter int PEAK_HOLD  = 30,
  parameter int PEAK_DECAY = 2
) (
  input  logic             lcd_clk,
  input  logic             sys_rst,
  input  logic [10:0]      pixel_xpos,
  input  logic [10:0]      pixel_ypos,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [IDX_W-1:0] bin_idx,
  input  logic [MAG_W-1:0] bin_mag,
  input  logic             bin_last,
  input  logic             peak_en,
  input  logic [15:0]      bar_color,
  input  logic [15:0]      peak_color,
  input  logic [15:0]      bg_color,
  output logic             swap_pulse,
  output logic [15:0]      lcd_data
);

  localparam int SH = $clog2(BAR_PITCH);
  localparam int HW = $clog2(PEAK_HOLD + 1);
  localparam logic [31:0] SPAN = 32'(N_BARS * BAR_PITCH);

  logic [10:0]    bank [2][N_BARS];
  logic [10:0]    peak [N_BARS];
  logic [HW-1:0]  hold [N_BARS];
  logic           disp_bank;
  logic           pending;

  logic           accept;
  logic           fe;
  logic           do_swap;
  logic           idx_ok;
  logic [10:0]    wr_len;

  logic [10:0]    rel;
  logic [10:0]    sub;
  logic [IDX_W-1:0] idx;
  logic           in_range;
  logic           in_bar;
  logic           upd;
  logic [10:0]    cur_len;
  logic [10:0]    cur_pk;
  logic [10:0]    dec_pk;
  logic [10:0]    decayed;

  assign bin_ready = ~pending & ~sys_rst;
  assign accept    = bin_valid & bin_ready;
  assign fe        = (pixel_xpos == 11'(H_DISP - 1))
                   && (pixel_ypos == 11'(V_DISP - 1));
  assign do_swap   = fe & pending;
  assign idx_ok    = 32'(bin_idx) < 32'(N_BARS);
  assign wr_len    = (32'(bin_mag) > 32'(H_DISP))
                   ? 11'(H_DISP) : 11'(bin_mag);

  // Row decode: slot index, lit-row test and peak update slot
  always_comb begin
    rel      = pixel_ypos - 11'(Y_OFFSET);
    in_range = (pixel_ypos >= 11'(Y_OFFSET))
             && (32'(rel) < SPAN);
    idx      = IDX_W'(rel >> SH);
    sub      = rel & 11'(BAR_PITCH - 1);
    in_bar   = in_range && (sub < 11'(BAR_THICK));
    upd      = in_range
             && (sub == 11'(BAR_THICK - 1))
             && (pixel_xpos == 11'(H_DISP - 1));
    cur_len  = bank[disp_bank][idx];
    cur_pk   = peak[idx];
    dec_pk   = (cur_pk > 11'(PEAK_DECAY))
             ? cur_pk - 11'(PEAK_DECAY) : 11'd0;
    decayed  = (dec_pk > cur_len) ? dec_pk : cur_len;
  end

  // Bank select, load-complete flag and swap strobe
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      disp_bank  <= 1'b0;
      pending    <= 1'b0;
      swap_pulse <= 1'b0;
    end else begin
      swap_pulse <= do_swap;
      if (do_swap) begin
        disp_bank <= ~disp_bank;
        pending   <= 1'b0;
      end else if (accept && bin_last) begin
        pending <= 1'b1;
      end
    end
  end

  // Magnitude writes into the hidden bank, clamped to row width
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N_BARS; i++)
          bank[b][i] <= 11'd0;
    end else if (accept && idx_ok) begin
      bank[~disp_bank][bin_idx] <= wr_len;
    end
  end

  // Peak-hold tracker, once per bar at the end of its last lit row
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < N_BARS; i++) begin
        peak[i] <= 11'd0;
        hold[i] <= '0;
      end
    end else if (upd) begin
      if (cur_len >= cur_pk) begin
        peak[idx] <= cur_len;
        hold[idx] <= HW'(PEAK_HOLD);
      end else if (hold[idx] != '0) begin
        hold[idx] <= hold[idx] - HW'(1);
      end else begin
        peak[idx] <= decayed;
      end
    end
  end

  // Registered pixel colour: peak marker over bar over background
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lcd_data <= 16'h0000;
    end else if (in_bar && peak_en && (cur_pk != 11'd0)
                 && (pixel_xpos == cur_pk - 11'd1)) begin
      lcd_data <= peak_color;
    end else if (in_bar && (pixel_xpos < cur_len)) begin
      lcd_data <= bar_color;
    end else begin
      lcd_data <= bg_color;
    end
  end

endmodule
